i2c_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares a single I2C master between `NUM_REQ` requesters (e.g. EEPROM controller, sensor poller, config loader). It captures one requester's command, drives the master's command interface, and watches the master's status flags for completion, NACK or hang. It retries NACKed transfers and returns read data and a status code to the granted requester.

---
 rtl/i2c_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters:
// captures a command, issues it, retries NACKs, and reports data/status back.
module i2c_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_RETRY      = 2,
    parameter int RETRY_GAP      = 64,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_din,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [7:0]           resp_dout,
    output logic [1:0]           resp_err,
    output logic                 arb_busy,
    output logic                 m_rw,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_din,
    output logic                 m_dataValid,
    input  logic [7:0]           m_dout,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_ackErr
);
    localparam int PTR_W    = $clog2(NUM_REQ);
    localparam int RTY_W    = $clog2(MAX_RETRY + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W    = $clog2(RETRY_GAP + 1);
    // GAP is left two counts early so the re-issue strobe, which trails ISSUE
    // by one register stage, lands exactly RETRY_GAP+1 cycles after the NACK.
    localparam int GAP_LAST = (RETRY_GAP > 1) ? RETRY_GAP - 2 : 0;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [RTY_W-1:0]     retry_cnt_q, retry_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 m_rw_q, m_rw_d;
    logic [6:0]           m_addr_q, m_addr_d;
    logic [7:0]           m_din_q, m_din_d;
    logic                 m_data_valid_q, m_data_valid_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [7:0]           resp_dout_q, resp_dout_d;
    logic [1:0]           resp_err_q, resp_err_d;
    logic                 arb_busy_q, arb_busy_d;

    logic [6:0]           addr_arr [NUM_REQ];
    logic [7:0]           din_arr  [NUM_REQ];
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fields
            assign addr_arr[gi] = req_addr[7*gi +: 7];
            assign din_arr[gi]  = req_din[8*gi +: 8];
        end
    endgenerate

    // Scan from the farthest offset down so the requester nearest ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (req[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_d        = grant_q;
        retry_cnt_d    = retry_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        m_rw_d         = m_rw_q;
        m_addr_d       = m_addr_q;
        m_din_d        = m_din_q;
        m_data_valid_d = 1'b0;
        resp_valid_d   = '0;
        resp_dout_d    = '0;
        resp_err_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found && !m_busy) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    m_rw_d           = req_rw[win_idx];
                    m_addr_d         = addr_arr[win_idx];
                    m_din_d          = din_arr[win_idx];
                    retry_cnt_d      = '0;
                    ptr_d            = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_data_valid_d = 1'b1;
                tmo_cnt_d      = '0;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                if (tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES - 1))
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (m_ackErr) begin
                    if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        gap_cnt_d   = '0;
                        state_d     = S_GAP;
                    end else begin
                        resp_valid_d = grant_q;
                        resp_err_d   = 2'b01;
                        state_d      = S_RESP;
                    end
                end else if (m_done) begin
                    resp_valid_d = grant_q;
                    resp_dout_d  = m_rw_q ? m_dout : 8'h00;
                    state_d      = S_RESP;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_valid_d = grant_q;
                    resp_err_d   = 2'b10;
                    state_d      = S_RESP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q != GAP_W'(RETRY_GAP))
                    gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q >= GAP_W'(GAP_LAST) && !m_busy)
                    state_d = S_ISSUE;
            end
            S_RESP: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        arb_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            grant_q        <= '0;
            retry_cnt_q    <= '0;
            tmo_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            m_rw_q         <= 1'b0;
            m_addr_q       <= '0;
            m_din_q        <= '0;
            m_data_valid_q <= 1'b0;
            resp_valid_q   <= '0;
            resp_dout_q    <= '0;
            resp_err_q     <= '0;
            arb_busy_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            retry_cnt_q    <= retry_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            m_rw_q         <= m_rw_d;
            m_addr_q       <= m_addr_d;
            m_din_q        <= m_din_d;
            m_data_valid_q <= m_data_valid_d;
            resp_valid_q   <= resp_valid_d;
            resp_dout_q    <= resp_dout_d;
            resp_err_q     <= resp_err_d;
            arb_busy_q     <= arb_busy_d;
        end
    end

    assign grant       = grant_q;
    assign resp_valid  = resp_valid_q;
    assign resp_dout   = resp_dout_q;
    assign resp_err    = resp_err_q;
    assign arb_busy    = arb_busy_q;
    assign m_rw        = m_rw_q;
    assign m_addr      = m_addr_q;
    assign m_din       = m_din_q;
    assign m_dataValid = m_data_valid_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: a behavioural I2C master model plus a linear
// sequence of transactions with hand-computed expectations.
module tb_i2c_arbiter;
    localparam int NREQ = 4;
    localparam int MAXR = 2;
    localparam int GAP  = 64;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_rw = '0;
    logic [27:0] req_addr = '0;
    logic [31:0] req_din = '0;
    logic [3:0]  grant, resp_valid;
    logic [7:0]  resp_dout;
    logic [1:0]  resp_err;
    logic        arb_busy, m_rw, m_dataValid;
    logic [6:0]  m_addr;
    logic [7:0]  m_din;
    logic [7:0]  m_dout = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_ackErr = 1'b0;

    int          cyc = 0, checks = 0, errors = 0;
    int          delay = 10, nack_cfg = 0, nack_base = 0, mcnt = 0;
    int          done_cyc = 0, resp_cnt = 0, busy_viol = 0;
    logic        hang = 1'b0, hang_rel = 1'b0;
    logic [7:0]  rd_data = '0;
    int          dv_times[$];

    i2c_arbiter #(.NUM_REQ(NREQ), .MAX_RETRY(MAXR), .RETRY_GAP(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_din(req_din),
        .grant(grant), .resp_valid(resp_valid), .resp_dout(resp_dout), .resp_err(resp_err),
        .arb_busy(arb_busy), .m_rw(m_rw), .m_addr(m_addr), .m_din(m_din), .m_dataValid(m_dataValid),
        .m_dout(m_dout), .m_busy(m_busy), .m_done(m_done), .m_ackErr(m_ackErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model: reacts just after each edge, so the DUT sees changes next edge.
    always @(posedge clk) begin
        #1;
        if (m_dataValid) begin
            dv_times.push_back(cyc);
            if (m_busy) busy_viol++;
        end
        if (resp_valid != '0) resp_cnt++;
        m_done   = 1'b0;
        m_ackErr = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            mcnt   = 0;
        end else if (m_dataValid && !m_busy) begin
            m_busy = 1'b1;
            mcnt   = 0;
        end else if (m_busy) begin
            mcnt++;
            if (hang) begin
                if (hang_rel) m_busy = 1'b0;
            end else if (mcnt >= delay) begin
                m_busy = 1'b0;
                m_dout = rd_data;
                if (dv_times.size() - nack_base <= nack_cfg) begin
                    m_ackErr = 1'b1;
                end else begin
                    m_done   = 1'b1;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int maxc, input string tag);
        int n;
        n = 0;
        while (grant == '0 && n < maxc) begin @(negedge clk); n++; end
        chk({tag, "_seen"}, 64'(grant != '0), 64'(1));
    endtask

    task automatic wait_resp(input int maxc, input string tag);
        int n;
        n = 0;
        while (resp_valid == '0 && n < maxc) begin @(negedge clk); n++; end
        chk({tag, "_seen"}, 64'(resp_valid != '0), 64'(1));
    endtask

    task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        req_rw[i]         = rw;
        req_addr[7*i +: 7] = a;
        req_din[8*i +: 8]  = d;
    endtask

    function automatic logic [63:0] all_out();
        return 64'({grant, resp_valid, resp_dout, resp_err, arb_busy,
                    m_rw, m_addr, m_din, m_dataValid});
    endfunction

    initial begin
        logic [3:0] e;
        int b, wcyc, rcnt;

        // Reset with all four requesters already asking
        rst = 1'b1;
        set_req(0, 1'b0, 7'h10, 8'h01);
        set_req(1, 1'b0, 7'h11, 8'h02);
        set_req(2, 1'b0, 7'h12, 8'h03);
        set_req(3, 1'b0, 7'h13, 8'h04);
        req   = 4'hF;
        delay = 20;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 64'(0));
        rst = 1'b0;

        // Round-robin 0,1,2,3,0 with each response before the next grant
        for (int i = 0; i < 5; i++) begin
            e = 4'(1 << (i % 4));
            wait_grant(50, "rr_grant");
            chk($sformatf("rr_grant%0d", i), 64'(grant), 64'(e));
            wait_resp(100, "rr_resp");
            chk($sformatf("rr_resp%0d", i), 64'(resp_valid), 64'(e));
            chk($sformatf("rr_hold%0d", i), 64'(grant), 64'(e));
            @(negedge clk);
            chk($sformatf("rr_release%0d", i), 64'(grant), 64'(0));
            if (i == 4) req = '0;
        end
        repeat (3) @(negedge clk);
        chk("rr_idle", 64'(arb_busy), 64'(0));

        // Single write from requester 2
        delay   = 300;
        rd_data = 8'hEE;
        set_req(2, 1'b0, 7'h50, 8'hA5);
        b   = dv_times.size();
        req = 4'b0100;
        @(negedge clk);
        chk("wr_grant", 64'(grant), 64'(4'b0100));
        chk("wr_addr", 64'(m_addr), 64'(7'h50));
        chk("wr_rw", 64'(m_rw), 64'(0));
        chk("wr_din", 64'(m_din), 64'(8'hA5));
        req = '0;
        set_req(2, 1'b1, 7'h7F, 8'h00);
        @(negedge clk);
        chk("wr_dv_pulse", 64'(m_dataValid), 64'(1));
        @(negedge clk);
        chk("wr_dv_end", 64'(m_dataValid), 64'(0));
        chk("wr_addr_held", 64'(m_addr), 64'(7'h50));
        wait_resp(400, "wr_resp");
        chk("wr_resp_valid", 64'(resp_valid), 64'(4'b0100));
        chk("wr_resp_err", 64'(resp_err), 64'(0));
        chk("wr_resp_dout", 64'(resp_dout), 64'(0));
        chk("wr_resp_lat", 64'(cyc), 64'(done_cyc + 1));
        chk("wr_dv_count", 64'(dv_times.size() - b), 64'(1));

        // Read from requester 1
        @(negedge clk);
        delay   = 10;
        rd_data = 8'h7E;
        set_req(1, 1'b1, 7'h3C, 8'h00);
        req = 4'b0010;
        @(negedge clk);
        chk("rd_grant", 64'(grant), 64'(4'b0010));
        chk("rd_rw", 64'(m_rw), 64'(1));
        chk("rd_addr", 64'(m_addr), 64'(7'h3C));
        req = '0;
        wait_resp(100, "rd_resp");
        chk("rd_resp_valid", 64'(resp_valid), 64'(4'b0010));
        chk("rd_resp_dout", 64'(resp_dout), 64'(8'h7E));
        chk("rd_resp_err", 64'(resp_err), 64'(0));
        chk("rd_resp_lat", 64'(cyc), 64'(done_cyc + 1));

        // Two NACKs then ACK
        @(negedge clk);
        nack_cfg  = 2;
        nack_base = dv_times.size();
        b         = nack_base;
        set_req(3, 1'b0, 7'h22, 8'h5A);
        req = 4'b1000;
        @(negedge clk);
        chk("nk_grant", 64'(grant), 64'(4'b1000));
        req = '0;
        wait_resp(600, "nk_resp");
        chk("nk_dv_count", 64'(dv_times.size() - b), 64'(3));
        for (int k = 1; k < 3; k++)
            chk($sformatf("nk_spacing%0d", k),
                64'((dv_times[b+k] - dv_times[b+k-1]) >= GAP + 1), 64'(1));
        chk("nk_resp_valid", 64'(resp_valid), 64'(4'b1000));
        chk("nk_resp_err", 64'(resp_err), 64'(0));

        // Three NACKs on a read: error 01 with zero data
        @(negedge clk);
        nack_cfg  = 3;
        nack_base = dv_times.size();
        b         = nack_base;
        rd_data   = 8'h99;
        set_req(3, 1'b1, 7'h22, 8'h00);
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        wait_resp(600, "nf_resp");
        chk("nf_dv_count", 64'(dv_times.size() - b), 64'(3));
        chk("nf_resp_valid", 64'(resp_valid), 64'(4'b1000));
        chk("nf_resp_err", 64'(resp_err), 64'(2'b01));
        chk("nf_resp_dout", 64'(resp_dout), 64'(0));
        nack_cfg = 0;

        // Timeout with the master hung, then blocked capture until m_busy falls
        @(negedge clk);
        hang = 1'b1;
        set_req(2, 1'b0, 7'h11, 8'h33);
        req = 4'b0100;
        @(negedge clk);
        chk("to_grant", 64'(grant), 64'(4'b0100));
        req = '0;
        @(negedge clk);
        chk("to_dv", 64'(m_dataValid), 64'(1));
        wcyc = cyc;
        wait_resp(1100, "to_resp");
        chk("to_lat", 64'(cyc - wcyc), 64'(TMO));
        chk("to_resp_err", 64'(resp_err), 64'(2'b10));
        chk("to_resp_valid", 64'(resp_valid), 64'(4'b0100));
        set_req(0, 1'b0, 7'h12, 8'h44);
        req = 4'b0001;
        b   = dv_times.size();
        repeat (40) @(negedge clk);
        chk("to_blocked_dv", 64'(dv_times.size() - b), 64'(0));
        chk("to_blocked_grant", 64'(grant), 64'(0));
        hang_rel = 1'b1;
        wait_grant(20, "to_regrant");
        chk("to_regrant", 64'(grant), 64'(4'b0001));
        req      = '0;
        hang     = 1'b0;
        hang_rel = 1'b0;
        delay    = 5;
        wait_resp(50, "to_after_resp");
        chk("to_after_err", 64'(resp_err), 64'(0));

        // Reset while in WAIT, then pointer restarts at requester 0
        @(negedge clk);
        hang = 1'b1;
        set_req(1, 1'b0, 7'h2A, 8'h77);
        req = 4'b0010;
        wait_grant(5, "rs_grant");
        chk("rs_grant", 64'(grant), 64'(4'b0010));
        req = '0;
        repeat (20) @(negedge clk);
        chk("rs_busy_wait", 64'(arb_busy), 64'(1));
        rcnt = resp_cnt;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_outputs", all_out(), 64'(0));
        hang = 1'b0;
        repeat (1100) @(negedge clk);
        chk("rs_no_resp", 64'(resp_cnt - rcnt), 64'(0));
        set_req(3, 1'b0, 7'h31, 8'h10);
        req = 4'b1010;
        @(negedge clk);
        chk("rs_ptr_restart", 64'(grant), 64'(4'b0010));
        req = '0;
        wait_resp(100, "rs_resp");
        chk("rs_resp_valid", 64'(resp_valid), 64'(4'b0010));

        chk("dv_while_busy", 64'(busy_viol), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
